// File: rtl/paula_audio_pkg.sv
// Shared Paula audio widths and constants, used by the volume stage and the mixer.
package paula_audio_pkg;
    localparam int AUD_SAMPLE_W = 8;
    localparam int AUD_VOL_W    = 6;
    localparam int AUD_PROD_W   = 14;
    localparam logic [AUD_VOL_W-1:0] AUD_VOL_MAX = 6'd63;
endpackage

// File: rtl/paula_audio_volume_scaler.sv
// Per-channel volume stage: signed 8-bit sample times unsigned 6-bit volume,
// registered into a signed 14-bit product with one clock of latency.
module paula_audio_volume_scaler
    import paula_audio_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [AUD_SAMPLE_W-1:0] sample,
    input  logic [AUD_VOL_W-1:0]    volume,
    output logic [AUD_PROD_W-1:0]   out
);
    logic [AUD_PROD_W-1:0]                sample_ext;
    logic [AUD_VOL_W-1:0][AUD_PROD_W-1:0] pp;
    logic [AUD_PROD_W-1:0]                out_d;
    logic [AUD_PROD_W-1:0]                out_q;

    assign sample_ext = {{(AUD_PROD_W-AUD_SAMPLE_W){sample[AUD_SAMPLE_W-1]}}, sample};

    // Volume is unsigned, so every partial product is added; the top one is never negated.
    for (genvar i = 0; i < AUD_VOL_W; i++) begin : g_pp
        assign pp[i] = volume[i] ? (sample_ext << i) : '0;
    end

    always_comb begin
        out_d = '0;
        for (int i = 0; i < AUD_VOL_W; i++) begin
            out_d = out_d + pp[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;
endmodule

// File: tb/tb_paula_audio_volume_scaler.sv
// Directed and exhaustive checks of the Paula volume stage against hand values
// and an integer signed-by-unsigned reference.
module tb_paula_audio_volume_scaler;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  sample;
    logic [5:0]  volume;
    logic [13:0] out;

    int n_vec = 0;
    int n_bad = 0;

    paula_audio_volume_scaler dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sample  (sample),
        .volume  (volume),
        .out     (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the next rising edge.
    task automatic apply(input logic [7:0] s, input logic [5:0] v);
        @(negedge clk);
        sample = s;
        volume = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  s8;
        logic [5:0]  v6;
        logic [13:0] exp14;
        int          p;

        reset_n = 1'b0;
        sample  = 8'h7F;
        volume  = 6'd63;
        #3;
        check("reset_initial", out, 14'h0000);
        @(posedge clk); #1;
        check("reset_hold_edge1", out, 14'h0000);
        @(posedge clk); #1;
        check("reset_hold_edge2", out, 14'h0000);
        @(negedge clk);
        reset_n = 1'b1;

        apply(8'h7F, 6'd63); check("pos_full", out, 14'h1F41);
        apply(8'h80, 6'd63); check("neg_full", out, 14'h2080);
        apply(8'hFF, 6'd1);  check("minus_one", out, 14'h3FFF);
        apply(8'h80, 6'd0);  check("vol_zero", out, 14'h0000);
        apply(8'h00, 6'd63); check("sample_zero", out, 14'h0000);
        apply(8'h01, 6'd32); check("vol_msb", out, 14'h0020);
        apply(8'hFE, 6'd33); check("neg_mixed", out, 14'h3FBE);

        // Back-to-back inputs, one product per clock.
        apply(8'h7F, 6'd63); check("pipe_0", out, 14'h1F41);
        apply(8'h80, 6'd63); check("pipe_1", out, 14'h2080);
        apply(8'h01, 6'd1);  check("pipe_2", out, 14'h0001);

        // Asynchronous reset mid-cycle, output still at full scale.
        apply(8'h7F, 6'd63); check("pre_reset", out, 14'h1F41);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_clear", out, 14'h0000);
        @(posedge clk); #1;
        check("reset_held", out, 14'h0000);
        @(negedge clk);
        sample  = 8'h40;
        volume  = 6'd32;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_release", out, 14'h0800);

        for (int s = 0; s < 256; s++) begin
            for (int v = 0; v < 64; v++) begin
                s8 = s[7:0];
                v6 = v[5:0];
                p = int'($signed(s8)) * v;
                exp14 = p[13:0];
                apply(s8, v6);
                check("sweep", out, exp14);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
